// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: FSM states, next-PC
// select-mux codes and the default width/vector constants.
package pc_seq_pkg;

    localparam int ADDR_W_DEF    = 17;
    localparam int VEC_RESET_DEF = 200;
    localparam int VEC_IRQ_DEF   = 22;
    localparam int VEC_TRAP_DEF  = 12;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        SEL_INC    = 4'd0,
        SEL_BRANCH = 4'd1,
        SEL_JUMP   = 4'd2,
        SEL_EPC    = 4'd3,
        SEL_IRQ    = 4'd4,
        SEL_TRAP   = 4'd5,
        SEL_RESET  = 4'd6
    } sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the pipeline/select-mux side (master) and the sequencer (slave).
interface pc_sequencer_if #(
    parameter int ADDR_W = pc_seq_pkg::ADDR_W_DEF
);
    logic              stall;
    logic              branch;
    logic              jump;
    logic              eret;
    logic              trap;
    logic              irq;
    logic              halt;
    logic [ADDR_W-1:0] next_addr;

    logic [3:0]        selection;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] vec_irq;
    logic [ADDR_W-1:0] vec_trap;
    logic [ADDR_W-1:0] vec_reset;
    logic              irq_ack;
    logic              in_isr;
    logic              fault;
    logic [1:0]        state;

    modport master (
        output stall, branch, jump, eret, trap, irq, halt, next_addr,
        input  selection, pc, pc_inc, epc, vec_irq, vec_trap, vec_reset,
               irq_ack, in_isr, fault, state
    );

    modport slave (
        input  stall, branch, jump, eret, trap, irq, halt, next_addr,
        output selection, pc, pc_inc, epc, vec_irq, vec_trap, vec_reset,
               irq_ack, in_isr, fault, state
    );
endinterface

// File: rtl/pc_seq_decode.sv
// Combinational priority decode: picks one action per cycle and turns it into
// a mux select, register load enables and the next FSM state.
module pc_seq_decode
    import pc_seq_pkg::*;
(
    input  state_t state,
    input  logic   in_isr,
    input  logic   stall,
    input  logic   trap,
    input  logic   irq,
    input  logic   eret,
    input  logic   halt,
    input  logic   jump,
    input  logic   branch,
    output sel_t   selection,
    output logic   irq_ack,
    output logic   load_pc,
    output logic   load_epc,
    output logic   set_isr,
    output logic   clr_isr,
    output logic   fault,
    output state_t state_next
);

    logic   act_ack;
    logic   act_pc;
    logic   act_epc;
    logic   act_set;
    logic   act_clr;
    logic   act_fault;
    state_t act_state;

    always_comb begin
        selection = SEL_INC;
        act_ack   = 1'b0;
        act_pc    = 1'b0;
        act_epc   = 1'b0;
        act_set   = 1'b0;
        act_clr   = 1'b0;
        act_fault = 1'b0;
        act_state = state;

        unique case (state)
            ST_BOOT: begin
                selection = SEL_RESET;
                act_pc    = 1'b1;
                act_state = ST_RUN;
            end
            ST_RUN: begin
                if (trap) begin
                    if (!in_isr) begin
                        selection = SEL_TRAP;
                        act_pc    = 1'b1;
                        act_epc   = 1'b1;
                        act_set   = 1'b1;
                    end else begin
                        act_fault = 1'b1;
                        act_state = ST_FAULT;
                    end
                end else if (irq && !in_isr) begin
                    selection = SEL_IRQ;
                    act_ack   = 1'b1;
                    act_pc    = 1'b1;
                    act_epc   = 1'b1;
                    act_set   = 1'b1;
                end else if (eret && in_isr) begin
                    selection = SEL_EPC;
                    act_pc    = 1'b1;
                    act_clr   = 1'b1;
                end else if (halt) begin
                    act_state = ST_HALTED;
                end else if (jump) begin
                    selection = SEL_JUMP;
                    act_pc    = 1'b1;
                end else if (branch) begin
                    selection = SEL_BRANCH;
                    act_pc    = 1'b1;
                end else begin
                    act_pc    = 1'b1;
                end
            end
            ST_HALTED: begin
                // Only an acceptable interrupt wakes the core; traps are ignored here.
                if (irq && !in_isr) begin
                    selection = SEL_IRQ;
                    act_ack   = 1'b1;
                    act_pc    = 1'b1;
                    act_epc   = 1'b1;
                    act_set   = 1'b1;
                    act_state = ST_RUN;
                end
            end
            default: begin
                act_fault = 1'b1;
            end
        endcase

        irq_ack    = act_ack & ~stall;
        load_pc    = act_pc & ~stall;
        load_epc   = act_epc & ~stall;
        set_isr    = act_set & ~stall;
        clr_isr    = act_clr & ~stall;
        fault      = (state == ST_FAULT) | (act_fault & ~stall);
        state_next = stall ? state : act_state;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds PC/EPC/ISR/FSM registers and drives the
// external next-PC select mux through the decode block.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int VEC_RESET = VEC_RESET_DEF,
    parameter int VEC_IRQ   = VEC_IRQ_DEF,
    parameter int VEC_TRAP  = VEC_TRAP_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] epc_reg;
    logic              in_isr_reg;
    state_t            state_reg;

    sel_t              selection;
    state_t            state_next;
    logic              irq_ack;
    logic              load_pc;
    logic              load_epc;
    logic              set_isr;
    logic              clr_isr;
    logic              fault;

    pc_seq_decode u_decode (
        .state      (state_reg),
        .in_isr     (in_isr_reg),
        .stall      (bus.stall),
        .trap       (bus.trap),
        .irq        (bus.irq),
        .eret       (bus.eret),
        .halt       (bus.halt),
        .jump       (bus.jump),
        .branch     (bus.branch),
        .selection  (selection),
        .irq_ack    (irq_ack),
        .load_pc    (load_pc),
        .load_epc   (load_epc),
        .set_isr    (set_isr),
        .clr_isr    (clr_isr),
        .fault      (fault),
        .state_next (state_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_BOOT;
            pc_reg     <= '0;
            epc_reg    <= '0;
            in_isr_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_pc) begin
                pc_reg <= bus.next_addr;
            end
            // EPC captures the current PC so the interrupted instruction re-executes.
            if (load_epc) begin
                epc_reg <= pc_reg;
            end
            if (set_isr) begin
                in_isr_reg <= 1'b1;
            end else if (clr_isr) begin
                in_isr_reg <= 1'b0;
            end
        end
    end

    assign bus.selection = selection;
    assign bus.irq_ack   = irq_ack;
    assign bus.fault     = fault;
    assign bus.pc        = pc_reg;
    assign bus.pc_inc    = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign bus.epc       = epc_reg;
    assign bus.in_isr    = in_isr_reg;
    assign bus.state     = state_reg;
    assign bus.vec_irq   = ADDR_W'(VEC_IRQ);
    assign bus.vec_trap  = ADDR_W'(VEC_TRAP);
    assign bus.vec_reset = ADDR_W'(VEC_RESET);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 17, program-counter and target width.
REQ-002 Parameter VEC_RESET, default 200, boot vector; VEC_IRQ, default 22, interrupt vector; VEC_TRAP, default 12, trap vector.
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Stall  in  1  freeze request from pipeline/memory.
REQ-006 Branch  in  1  conditional branch taken this cycle (target on branch-target mux leg).
REQ-007 Jump  in  1  unconditional jump this cycle.
REQ-008 Eret  in  1  return-from-interrupt this cycle.
REQ-009 Trap  in  1  synchronous exception (illegal op / software trap).
REQ-010 Irq  in  1  level-sensitive external interrupt, held by source until IrqAck.
REQ-011 Halt  in  1  halt instruction executing.
REQ-012 NextAddr  in  ADDR_W  next-PC select-mux output, loaded into PC.
REQ-013 Selection  out  4  next-PC select-mux code: 0 PcInc, 1 branch target, 2 jump target, 3 Epc, 4 VEC_IRQ, 5 VEC_TRAP, 6 VEC_RESET.
REQ-014 Pc  out  ADDR_W  current program counter; PcInc  out  ADDR_W  Pc+1; Epc  out  ADDR_W  saved return address.
REQ-015 IrqAck  out  1  one-cycle interrupt acknowledge; InIsr  out  1  handler active; Fault  out  1  double fault; State  out  2  FSM state.

Function
REQ-016 FSM states SHALL be BOOT(0), RUN(1), HALTED(2), FAULT(3).
REQ-017 Selection, IrqAck SHALL be combinational from state and inputs; Pc, Epc, InIsr, State registered; event in cycle N gives Pc = NextAddr after edge N (zero-bubble, one-edge latency).
REQ-018 PcInc SHALL be Pc+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-019 BOOT: Selection=6; on the first unstalled edge Pc<=NextAddr, State<=RUN.
REQ-020 RUN, unstalled, priority Trap > Irq(InIsr=0) > Eret(InIsr=1) > Halt > Jump > Branch > sequential; exactly one action per cycle, lower events dropped.
REQ-021 Trap with InIsr=0: Selection=5, Epc<=Pc, InIsr<=1, Pc<=NextAddr.
REQ-022 Trap with InIsr=1: State<=FAULT, Pc and Epc hold, Fault=1.
REQ-023 Irq with InIsr=0: Selection=4, IrqAck=1 that cycle, Epc<=Pc (interrupted instruction re-executes), InIsr<=1, Pc<=NextAddr.
REQ-024 Irq with InIsr=1: ignored; IrqAck=0.
REQ-025 Eret with InIsr=1: Selection=3, InIsr<=0, Pc<=NextAddr; Eret with InIsr=0 treated as sequential.
REQ-026 Halt: State<=HALTED, Pc holds at halt instruction, Selection=0.
REQ-027 Jump: Selection=2; Branch: Selection=1; otherwise Selection=0; each Pc<=NextAddr.
REQ-028 HALTED: Pc holds; Irq with InIsr=0 performs REQ-023 and State<=RUN; Trap ignored; all else ignored.
REQ-029 FAULT: Selection=0, Pc/Epc/InIsr hold, Fault=1; exit only via Reset_n.
REQ-030 Stall=1 (any state except FAULT): no register updates, IrqAck=0, Selection still reflects the pending decision.

Reset
REQ-031 On Reset_n=0, immediately: State=BOOT, Pc=0, Epc=0, InIsr=0; outputs Selection=6, IrqAck=0, Fault=0, PcInc=1.
REQ-032 Reset assertion mid-ISR or mid-stall SHALL discard all context; deassertion SHALL give no action until the next rising edge.

Structure
REQ-033 Package pc_seq_pkg SHALL hold state encodings, Selection codes, ADDR_W default and the three vector defaults, shared with the select mux and top level.
REQ-034 One sub-module pc_seq_decode (combinational priority decode -> Selection, load enables, next state) SHALL be used; registers live in pc_sequencer.

Verification
REQ-035 Reset, NextAddr=200 -> Selection=6; after one edge Pc=200, State=RUN; next cycle Selection=0, PcInc=201.
REQ-036 Pc=50, Irq=1, Branch=1 same cycle -> Selection=4, IrqAck=1, Epc=50, Pc=22, InIsr=1; Irq held next cycle -> IrqAck=0.
REQ-037 In ISR Pc=30, Eret=1 with NextAddr=Epc=50 -> Selection=3, Pc=50, InIsr=0.
REQ-038 In ISR, Trap=1 -> State=FAULT, Fault=1, Pc frozen until Reset_n low.
REQ-039 Pc=40, Stall=1 with Jump=1 for 3 cycles -> Pc=40, Selection=2 throughout; Stall=0 -> Pc=jump target.
REQ-040 Pc=131071 sequential -> PcInc=0, Pc=0; Halt=1 -> HALTED; Irq=1 -> Pc=22, State=RUN.
